// File: rtl/bp_cache_req_arbiter.sv
// ============================================================================
// Module      : bp_cache_req_arbiter
// Description : Round-robin share of one cache-engine request path between
//               the I$ (port 0) and D$ (port 1). Optional per-port grant
//               counters are built when BP_CACHE_ARB_GRANT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_cache_req_arbiter #(
    parameter int req_width_p      = 96,
    parameter int metadata_width_p = 8,
    parameter int ctr_width_p      = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic [2*req_width_p-1:0]      req_i,
    input  logic [1:0]                    req_v_i,
    output logic [1:0]                    req_yumi_o,
    input  logic [2*metadata_width_p-1:0] req_metadata_i,
    input  logic [1:0]                    req_metadata_v_i,
    output logic [1:0]                    req_last_o,
    output logic [1:0]                    req_critical_o,
    output logic [1:0]                    req_lock_o,

    output logic [req_width_p-1:0]        engine_req_o,
    output logic                          engine_req_v_o,
    input  logic                          engine_req_yumi_i,
    output logic [metadata_width_p-1:0]   engine_metadata_o,
    output logic                          engine_metadata_v_o,
    input  logic                          engine_last_i,
    input  logic                          engine_critical_i,
    input  logic                          engine_lock_i,
    input  logic                          engine_credits_full_i,

    output logic [2*ctr_width_p-1:0]      grant_cnt_o
);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_grant = 2'd1,
        e_busy  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q,  last_d;

    logic                        w_own_v;
    logic [req_width_p-1:0]      w_own_req;
    logic [metadata_width_p-1:0] w_own_meta;
    logic                        w_own_meta_v;

    assign w_own_v      = owner_q ? req_v_i[1] : req_v_i[0];
    assign w_own_req    = owner_q ? req_i[2*req_width_p-1:req_width_p] : req_i[req_width_p-1:0];
    assign w_own_meta   = owner_q ? req_metadata_i[2*metadata_width_p-1:metadata_width_p]
                                  : req_metadata_i[metadata_width_p-1:0];
    assign w_own_meta_v = owner_q ? req_metadata_v_i[1] : req_metadata_v_i[0];

    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        last_d              = last_q;
        req_yumi_o          = 2'b00;
        req_last_o          = 2'b00;
        req_critical_o      = 2'b00;
        req_lock_o          = 2'b00;
        engine_req_o        = '0;
        engine_req_v_o      = 1'b0;
        engine_metadata_o   = '0;
        engine_metadata_v_o = 1'b0;

        case (state_q)
            e_idle: begin
                if ((|req_v_i) && !engine_credits_full_i) begin
                    // Contention goes to the port that did not win last time.
                    owner_d = (&req_v_i) ? ~last_q : req_v_i[1];
                    state_d = e_grant;
                end
            end
            e_grant: begin
                engine_req_o        = w_own_req;
                engine_req_v_o      = w_own_v;
                req_yumi_o[owner_q] = engine_req_yumi_i & w_own_v;
                if (engine_req_yumi_i && w_own_v) begin
                    last_d  = owner_q;
                    state_d = e_busy;
                end else if (!w_own_v) begin
                    state_d = e_idle;
                end
            end
            e_busy: begin
                engine_metadata_o       = w_own_meta;
                engine_metadata_v_o     = w_own_meta_v;
                req_last_o[owner_q]     = engine_last_i;
                req_critical_o[owner_q] = engine_critical_i;
                req_lock_o[owner_q]     = engine_lock_i;
                if (engine_last_i) begin
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase

        // Outputs are quiet while reset is held, whatever state the flops hold.
        if (reset_i) begin
            req_yumi_o          = 2'b00;
            req_last_o          = 2'b00;
            req_critical_o      = 2'b00;
            req_lock_o          = 2'b00;
            engine_req_o        = '0;
            engine_req_v_o      = 1'b0;
            engine_metadata_o   = '0;
            engine_metadata_v_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef BP_CACHE_ARB_GRANT_CNT_EN
    logic [1:0][ctr_width_p-1:0] grant_cnt_q, grant_cnt_d;

    for (genvar p = 0; p < 2; p++) begin : g_grant_cnt
        always_comb begin
            grant_cnt_d[p] = grant_cnt_q[p];
            if (req_yumi_o[p] && !(&grant_cnt_q[p])) begin
                grant_cnt_d[p] = grant_cnt_q[p] + {{(ctr_width_p-1){1'b0}}, 1'b1};
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                grant_cnt_q[p] <= '0;
            end else begin
                grant_cnt_q[p] <= grant_cnt_d[p];
            end
        end
    end

    assign grant_cnt_o = reset_i ? '0 : grant_cnt_q;
`else
    assign grant_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_cache_req_arbiter.sv
// ============================================================================
// Module      : tb_bp_cache_req_arbiter
// Description : Scoreboard bench for bp_cache_req_arbiter with a simple
//               engine model; expected grants/fills are queued by stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bp_cache_req_arbiter;

    localparam int RW = 96;
    localparam int MW = 8;
    localparam int CW = 4;

    localparam logic [RW-1:0] PKT_A = 96'hA1A1_0000_1111_2222_3333_0001;
    localparam logic [RW-1:0] PKT_C = 96'hC3C3_0000_4444_5555_6666_0003;
    localparam logic [RW-1:0] PKT_D = 96'hD4D4_0000_7777_8888_9999_0004;
    localparam logic [RW-1:0] PKT_E = 96'hE5E5_0000_AAAA_BBBB_CCCC_0005;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [2*RW-1:0]   req_i;
    logic [1:0]        req_v_i;
    logic [1:0]        req_yumi_o;
    logic [2*MW-1:0]   req_metadata_i;
    logic [1:0]        req_metadata_v_i;
    logic [1:0]        req_last_o, req_critical_o, req_lock_o;
    logic [RW-1:0]     engine_req_o;
    logic              engine_req_v_o;
    logic              engine_req_yumi_i;
    logic [MW-1:0]     engine_metadata_o;
    logic              engine_metadata_v_o;
    logic              engine_last_i, engine_critical_i, engine_lock_i, engine_credits_full_i;
    logic [2*CW-1:0]   grant_cnt_o;

    always #5 clk = ~clk;

    bp_cache_req_arbiter #(
        .req_width_p      (RW),
        .metadata_width_p (MW),
        .ctr_width_p      (CW)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .req_i                 (req_i),
        .req_v_i               (req_v_i),
        .req_yumi_o            (req_yumi_o),
        .req_metadata_i        (req_metadata_i),
        .req_metadata_v_i      (req_metadata_v_i),
        .req_last_o            (req_last_o),
        .req_critical_o        (req_critical_o),
        .req_lock_o            (req_lock_o),
        .engine_req_o          (engine_req_o),
        .engine_req_v_o        (engine_req_v_o),
        .engine_req_yumi_i     (engine_req_yumi_i),
        .engine_metadata_o     (engine_metadata_o),
        .engine_metadata_v_o   (engine_metadata_v_o),
        .engine_last_i         (engine_last_i),
        .engine_critical_i     (engine_critical_i),
        .engine_lock_i         (engine_lock_i),
        .engine_credits_full_i (engine_credits_full_i),
        .grant_cnt_o           (grant_cnt_o)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0]    port;
        logic [RW-1:0] pkt;
    } exp_t;

    exp_t       yq[$];
    logic [1:0] lq[$];

    logic eng_auto;
    int   fill_len;

    // Engine takes a request as soon as it is offered while eng_auto is set.
    assign engine_req_yumi_i = eng_auto & engine_req_v_o;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {14'd0, engine_req_o, req_yumi_o, req_last_o, req_critical_o, req_lock_o,
                engine_req_v_o, engine_metadata_v_o, engine_metadata_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_yumi(input int port, input int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_yumi_o[port] && n < maxc);
        if (!req_yumi_o[port]) check("yumi_timeout", req_yumi_o, 2'b01 << port);
    endtask

    task automatic wait_last(input int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_last_o == 2'b00 && n < maxc);
        if (req_last_o == 2'b00) check("last_timeout", req_last_o, 2'b11);
    endtask

    task automatic do_reset();
        tick();
        reset_i = 1'b1;
        @(negedge clk);
        check("in_reset_outputs", all_outs(), 0);
        check("in_reset_cnt", grant_cnt_o, 0);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", all_outs(), 0);
        check("post_reset_cnt", grant_cnt_o, 0);
    endtask

    // Engine model: last arrives on the fill_len-th busy cycle after yumi.
    initial begin
        int   cnt;
        logic y, r;
        cnt           = 0;
        engine_last_i = 1'b0;
        forever begin
            @(negedge clk);
            y = engine_req_yumi_i;
            r = reset_i;
            @(posedge clk);
            #1;
            engine_last_i = 1'b0;
            if (r)          cnt = 0;
            else if (y)     cnt = fill_len;
            else if (cnt > 0) cnt--;
            if (cnt == 1) engine_last_i = 1'b1;
        end
    end

    // Monitor: every grant and every fill-complete pops the scoreboard.
    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] l;
        if (req_yumi_o != 2'b00) begin
            if (yq.size() == 0) begin
                check("yumi_unexpected", req_yumi_o, 2'b00);
            end else begin
                e = yq.pop_front();
                check("yumi_port", req_yumi_o, e.port);
                check("grant_pkt", engine_req_o, e.pkt);
            end
        end
        if (req_last_o != 2'b00) begin
            if (lq.size() == 0) begin
                check("last_unexpected", req_last_o, 2'b00);
            end else begin
                l = lq.pop_front();
                check("last_port", req_last_o, l);
            end
        end
    end

    initial begin
        logic [CW-1:0] exp_mid, exp_sat;
`ifdef BP_CACHE_ARB_GRANT_CNT_EN
        exp_mid = 4'hA;
        exp_sat = 4'hF;
`else
        exp_mid = 4'h0;
        exp_sat = 4'h0;
`endif
        reset_i               = 1'b1;
        req_i                 = '0;
        req_v_i               = 2'b00;
        req_metadata_i        = '0;
        req_metadata_v_i      = 2'b00;
        engine_critical_i     = 1'b0;
        engine_lock_i         = 1'b0;
        engine_credits_full_i = 1'b0;
        eng_auto              = 1'b1;
        fill_len              = 3;

        do_reset();

        // Single I$ request with the engine holding off yumi for one cycle.
        tick();
        req_i[RW-1:0] = PKT_A;
        req_v_i       = 2'b01;
        eng_auto      = 1'b0;
        fill_len      = 4;
        yq.push_back({2'b01, PKT_A});
        lq.push_back(2'b01);
        @(negedge clk);
        check("t1_grant_registered", engine_req_v_o, 0);
        @(negedge clk);
        check("t1_grant_v", engine_req_v_o, 1);
        check("t1_no_yumi_yet", req_yumi_o, 0);
        tick();
        eng_auto = 1'b1;
        wait_yumi(0, 4);
        tick();
        req_v_i = 2'b00;
        @(negedge clk);
        check("t1_busy_no_v", engine_req_v_o, 0);
        wait_last(10);
        @(negedge clk);
        check("t1_idle_after_last", all_outs(), 0);

        // Both ports requesting from reset: D$, I$, D$.
        do_reset();
        tick();
        req_i    = {PKT_D, PKT_C};
        req_v_i  = 2'b11;
        fill_len = 2;
        yq.push_back({2'b10, PKT_D}); lq.push_back(2'b10);
        yq.push_back({2'b01, PKT_C}); lq.push_back(2'b01);
        yq.push_back({2'b10, PKT_D}); lq.push_back(2'b10);
        wait_yumi(1, 10);
        wait_yumi(0, 10);
        wait_yumi(1, 10);
        tick();
        req_v_i = 2'b00;
        wait_last(10);
        @(negedge clk);

        // D$ owns the engine; I$ metadata must not leak through.
        tick();
        req_i[2*RW-1:RW] = PKT_E;
        req_v_i          = 2'b10;
        fill_len         = 6;
        yq.push_back({2'b10, PKT_E});
        lq.push_back(2'b10);
        wait_yumi(1, 6);
        tick();
        req_v_i           = 2'b00;
        req_metadata_i    = {8'h22, 8'h11};
        req_metadata_v_i  = 2'b01;
        engine_critical_i = 1'b1;
        @(negedge clk);
        check("t3_meta_v_nonowner", engine_metadata_v_o, 0);
        check("t3_critical_owner", req_critical_o, 2'b10);
        check("t3_lock_idle", req_lock_o, 2'b00);
        tick();
        req_metadata_v_i  = 2'b10;
        engine_critical_i = 1'b0;
        engine_lock_i     = 1'b1;
        @(negedge clk);
        check("t3_meta_v_owner", engine_metadata_v_o, 1);
        check("t3_meta_data", engine_metadata_o, 8'h22);
        check("t3_lock_owner", req_lock_o, 2'b10);
        check("t3_critical_clear", req_critical_o, 2'b00);
        tick();
        req_metadata_v_i = 2'b00;
        engine_lock_i    = 1'b0;
        wait_last(10);
        @(negedge clk);

        // Credits full blocks arbitration; last winner was D$ so I$ goes next.
        tick();
        engine_credits_full_i = 1'b1;
        req_i    = {PKT_D, PKT_C};
        req_v_i  = 2'b11;
        fill_len = 2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_blocked", engine_req_v_o, 0);
        end
        yq.push_back({2'b01, PKT_C});
        lq.push_back(2'b01);
        tick();
        engine_credits_full_i = 1'b0;
        @(negedge clk);
        check("t4_decide_cycle", engine_req_v_o, 0);
        @(negedge clk);
        check("t4_grant_v", engine_req_v_o, 1);
        tick();
        req_v_i = 2'b00;
        wait_last(10);
        @(negedge clk);

        // Reset while busy; afterwards D$ has priority again.
        tick();
        req_i[RW-1:0] = PKT_A;
        req_v_i       = 2'b01;
        fill_len      = 6;
        yq.push_back({2'b01, PKT_A});
        wait_yumi(0, 6);
        tick();
        req_v_i = 2'b00;
        @(negedge clk);
        tick();
        reset_i = 1'b1;
        @(negedge clk);
        check("t5_in_reset", all_outs(), 0);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        check("t5_after_reset", all_outs(), 0);
        tick();
        req_i    = {PKT_D, PKT_C};
        req_v_i  = 2'b11;
        fill_len = 1;
        yq.push_back({2'b10, PKT_D});
        lq.push_back(2'b10);
        wait_yumi(1, 6);
        tick();
        req_v_i = 2'b00;
        wait_last(5);
        @(negedge clk);

        // Grant counters: 20 D$ grants saturate a 4-bit counter.
        do_reset();
        tick();
        req_i[2*RW-1:RW] = PKT_E;
        req_v_i          = 2'b10;
        fill_len         = 1;
        for (int i = 0; i < 20; i++) begin
            yq.push_back({2'b10, PKT_E});
            lq.push_back(2'b10);
        end
        for (int i = 0; i < 20; i++) begin
            wait_yumi(1, 8);
            if (i == 9) begin
                tick();
                @(negedge clk);
                check("t6_cnt_mid", grant_cnt_o[2*CW-1:CW], exp_mid);
            end
        end
        tick();
        req_v_i = 2'b00;
        wait_last(5);
        @(negedge clk);
        check("t6_cnt_dcache", grant_cnt_o[2*CW-1:CW], exp_sat);
        check("t6_cnt_icache", grant_cnt_o[CW-1:0], 0);

        repeat (3) @(negedge clk);
        check("yumi_queue_drained", yq.size(), 0);
        check("last_queue_drained", lq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
